// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-bus to single-port SRAM responder.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_e;

  localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;
  localparam int          WAIT_CNT_W = 2;
  localparam int          ERR_CNT_W  = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
    logic [ERR_CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/picorv32_mem_decode.sv
// Address window and word-alignment check for the SRAM responder.
module picorv32_mem_decode #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 9
) (
  input  logic [31:0] mem_addr,
  output logic        hit
);

  // Only the bits above the word-address field select the window.
  localparam logic [31:0] TAG_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

  logic tag_match;
  logic aligned;

  assign tag_match = (((mem_addr ^ BASE_ADDR) & TAG_MASK) == 32'h0000_0000);
  assign aligned   = (mem_addr[1:0] == 2'b00);
  assign hit       = tag_match && aligned;

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32 native memory bus responder driving an external single-port SRAM macro.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 9,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0,
  output logic                  bus_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  mem_state_e            state_q, state_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic hit;
  logic instr_unused;

  assign instr_unused = mem_instr;

  picorv32_mem_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .mem_addr (mem_addr),
    .hit      (hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = 1'b0;
    err_count_d = err_count_q;
    // Chip select and write enable are strobes: asserted only for the ISSUE cycle.
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          if (hit) begin
            csb_d   = 1'b0;
            web_d   = ~|mem_wstrb;
            wmask_d = mem_wstrb;
            addr_d  = mem_addr[ADDR_WIDTH+1:2];
            din_d   = mem_wdata;
            state_d = ST_ISSUE;
          end else begin
            mem_rdata_d = ERR_RDATA;
            bus_err_d   = 1'b1;
            mem_ready_d = 1'b1;
            err_count_d = sat_inc(err_count_q);
            state_d     = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        // web_q still holds the accepted request's direction.
        if (!web_q) begin
          mem_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = WAIT_INIT;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          mem_rdata_d = sram_dout0;
          mem_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      bus_err_q   <= 1'b0;
      err_count_q <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= 4'b0000;
      addr_q      <= '0;
      din_q       <= 32'h0000_0000;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      err_count_q <= err_count_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign bus_err     = bus_err_q;
  assign err_count   = err_count_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed scoreboard bench: one responder with no wait states, one with three.
module tb_picorv32_mem_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst0, rst1;
  logic        valid0, valid1;
  logic        mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        ready0, ready1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        csb0, csb1, web0, web1;
  logic [3:0]  wmask0, wmask1;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;
  logic [7:0]  errcnt0, errcnt1;

  logic [31:0] sram0 [512];
  logic [31:0] sram1 [512];
  int          acc0, acc1;

  logic [31:0] shadow [2][512];
  logic [31:0] last_rd [2];
  exp_t        q0[$];
  exp_t        q1[$];

  int          n_checks, n_pass;
  int          csb_cyc;
  logic [8:0]  cap_addr;
  logic        cap_web;
  logic [3:0]  cap_mask;
  logic [31:0] cap_din;

  picorv32_mem_responder #(.BASE_ADDR(32'h0000_0000), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_valid(valid0), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready0), .mem_rdata(rdata0),
    .sram_csb0(csb0), .sram_web0(web0), .sram_wmask0(wmask0), .sram_addr0(addr0),
    .sram_din0(din0), .sram_dout0(dout0), .bus_err(err0), .err_count(errcnt0));

  picorv32_mem_responder #(.BASE_ADDR(32'h0000_0000), .ADDR_WIDTH(9), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(rst1), .mem_valid(valid1), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready1), .mem_rdata(rdata1),
    .sram_csb0(csb1), .sram_web0(web1), .sram_wmask0(wmask1), .sram_addr0(addr1),
    .sram_din0(din1), .sram_dout0(dout1), .bus_err(err1), .err_count(errcnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAMs: dout updates one cycle after a read is sampled and then holds.
  always @(posedge clk) begin
    if (!csb0) begin
      acc0 <= acc0 + 1;
      if (!web0) begin
        for (int i = 0; i < 4; i++) if (wmask0[i]) sram0[addr0][8*i +: 8] <= din0[8*i +: 8];
      end else begin
        dout0 <= sram0[addr0];
      end
    end
  end

  always @(posedge clk) begin
    if (!csb1) begin
      acc1 <= acc1 + 1;
      if (!web1) begin
        for (int i = 0; i < 4; i++) if (wmask1[i]) sram1[addr1][8*i +: 8] <= din1[8*i +: 8];
      end else begin
        dout1 <= sram1[addr1];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (ready0) begin
      chk("ready0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("rdata0", rdata0, e.rd);
        chk("bus_err0", 32'(err0), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ready1) begin
      chk("ready1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("rdata1", rdata1, e.rd);
        chk("bus_err1", 32'(err1), 32'(e.err));
      end
    end
  end

  task automatic drop_valid(input int d);
    if (d == 0) valid0 = 1'b0; else valid1 = 1'b0;
    mem_addr  = 32'hFFFF_FFF3;
    mem_wdata = 32'hDEAD_BEEF;
    mem_wstrb = 4'hF;
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit hold, input bit follow);
    exp_t       e;
    int         lat, exp_lat;
    logic       rdy, inr;
    logic [8:0] w;
    if (!follow) @(negedge clk);
    inr = (a[31:11] == 21'd0) && (a[1:0] == 2'b00);
    w   = a[10:2];
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = (ws == 4'h0);
    if (d == 0) valid0 = 1'b1; else valid1 = 1'b1;
    if (!inr) begin
      e.rd = 32'h0; e.err = 1'b1; last_rd[d] = 32'h0; exp_lat = 1;
    end else if (ws != 4'h0) begin
      for (int i = 0; i < 4; i++) if (ws[i]) shadow[d][w][8*i +: 8] = wd[8*i +: 8];
      e.rd = last_rd[d]; e.err = 1'b0; exp_lat = 2;
    end else begin
      e.rd = shadow[d][w]; e.err = 1'b0; last_rd[d] = e.rd; exp_lat = (d == 0) ? 3 : 6;
    end
    exp_lat = exp_lat + (follow ? 1 : 0);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    csb_cyc = 0; rdy = 1'b0; lat = 0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = (d == 0) ? ready0 : ready1;
      if (((d == 0) ? csb0 : csb1) == 1'b0) begin
        csb_cyc++;
        cap_addr = (d == 0) ? addr0 : addr1;
        cap_web  = (d == 0) ? web0 : web1;
        cap_mask = (d == 0) ? wmask0 : wmask1;
        cap_din  = (d == 0) ? din0 : din1;
      end
      if (!hold && lat >= 1 + (follow ? 1 : 0)) drop_valid(d);
    end
    chk($sformatf("latency_dut%0d_addr%h", d, a), lat, exp_lat);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int seen, acc_before;
    logic [31:0] a;
    n_checks = 0; n_pass = 0; acc0 = 0; acc1 = 0;
    rst0 = 1'b1; rst1 = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_bus_err0", 32'(err0), 32'd0);
    chk("rst_csb0", 32'(csb0), 32'd1);
    chk("rst_web0", 32'(web0), 32'd1);
    chk("rst_wmask0", 32'(wmask0), 32'd0);
    chk("rst_addr0", 32'(addr0), 32'd0);
    chk("rst_din0", din0, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_errcnt0", 32'(errcnt0), 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_csb1", 32'(csb1), 32'd1);

    // Full-word write, then read back with no wait states.
    txn(0, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b0, 1'b0);
    chk("wr_csb_cycles", csb_cyc, 1);
    chk("wr_addr0", 32'(cap_addr), 32'd4);
    chk("wr_web0", 32'(cap_web), 32'd0);
    chk("wr_wmask0", 32'(cap_mask), 32'hF);
    chk("wr_din0", cap_din, 32'hA5A5_1234);
    chk("wr_csb_released", 32'(csb0), 32'd1);
    txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("rd_csb_cycles", csb_cyc, 1);
    chk("rd_web0", 32'(cap_web), 32'd1);
    chk("rd_data_ws0", rdata0, 32'hA5A5_1234);

    // Single-byte write merges into the existing word.
    txn(0, 32'h0000_0010, 32'h0000_FF00, 4'b0010, 1'b0, 1'b0);
    chk("bw_wmask0", 32'(cap_mask), 32'h2);
    chk("bw_rdata_unchanged", rdata0, 32'hA5A5_1234);
    txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("bw_read", rdata0, 32'hA5A5_FF34);

    // Rejected requests: out of range, misaligned, then saturation.
    acc_before = acc0;
    txn(0, 32'h0000_1000, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("err_oor_count", 32'(errcnt0), 32'd1);
    txn(0, 32'h0000_0012, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("err_mis_count", 32'(errcnt0), 32'd2);
    chk("err_no_sram", acc0 - acc_before, 0);
    for (int i = 0; i < 252; i++) begin
      a = (i % 2 == 0) ? ($urandom | 32'h0000_0800) : (($urandom & 32'h0000_07FF) | 32'h1);
      txn(0, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    chk("err_count_254", 32'(errcnt0), 32'hFE);
    txn(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("err_count_255", 32'(errcnt0), 32'hFF);
    for (int i = 0; i < 45; i++) txn(0, $urandom | 32'h0000_1000, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("err_count_sat", 32'(errcnt0), 32'hFF);

    // Back-to-back write then read with mem_valid held high.
    acc_before = acc0;
    txn(0, 32'h0000_0040, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    txn(0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("b2b_read", rdata0, 32'h1234_5678);
    chk("b2b_sram_accesses", acc0 - acc_before, 2);

    // Reset during ISSUE: the write still lands, no response follows.
    @(negedge clk);
    mem_addr = 32'h0000_0020; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF; valid0 = 1'b1;
    @(negedge clk);
    drop_valid(0); rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    shadow[0][8] = 32'hCAFE_F00D; last_rd[0] = 32'h0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ready0) seen++; end
    chk("rst_issue_no_ready", seen, 0);
    chk("rst_issue_errcnt", 32'(errcnt0), 32'd0);
    chk("rst_issue_rdata", rdata0, 32'd0);
    txn(0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_issue_readback", rdata0, 32'hCAFE_F00D);

    // Reset in IDLE with a pending request: no SRAM access.
    acc_before = acc0;
    @(negedge clk);
    mem_addr = 32'h0000_0030; mem_wdata = 32'h1111_1111; mem_wstrb = 4'hF; valid0 = 1'b1; rst0 = 1'b1;
    @(negedge clk);
    drop_valid(0); rst0 = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ready0) seen++; end
    chk("rst_idle_no_sram", acc0 - acc_before, 0);
    chk("rst_idle_no_ready", seen, 0);

    // Three wait states.
    txn(1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b0, 1'b0);
    txn(1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("rd_data_ws3", rdata1, 32'hA5A5_1234);

    // Reset during WAIT aborts the read; the next read completes normally.
    @(negedge clk);
    mem_addr = 32'h0000_0010; mem_wstrb = 4'h0; valid1 = 1'b1;
    @(negedge clk);
    drop_valid(1);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("rst_wait_csb1", 32'(csb1), 32'd1);
    chk("rst_wait_ready1", 32'(ready1), 32'd0);
    last_rd[1] = 32'h0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (ready1) seen++; end
    chk("rst_wait_no_ready", seen, 0);
    txn(1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_wait_readback", rdata1, 32'hA5A5_1234);

    repeat (3) @(negedge clk);
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
